press_reporter: RTL and testbench
=================================

PRESS_REPORTER -- requirements
Module: press_reporter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port press_pulse, input, 1, one-cycle press strobe from the debouncer.
REQ-005 SHALL have port tx, output, 1, UART serial line, 8N1, idle high.
REQ-006 SHALL have port busy, output, 1, high while a message is in flight or pending.
REQ-007 SHALL have port press_count, output, 8, running press total.

Function
REQ-008 SHALL increment press_count by 1 on every cycle press_pulse is high, modulo 256 (255 -> 0).
REQ-009 SHALL report each accepted press as a 4-byte message: two uppercase ASCII hex digits of the snapshot count (high nibble first), then 0x0D, then 0x0A.
REQ-010 SHALL take the snapshot as the post-increment count at message start.
REQ-011 SHALL frame each byte as: start bit (0), 8 data bits LSB first, stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-012 SHALL send all 4 bytes back-to-back with no idle gap, for a message length of 40*CLKS_PER_BIT cycles.
REQ-013 SHALL use the FSM states IDLE, START, DATA and STOP, with these transitions:
- IDLE->START on a press.
- START->DATA after one bit time.
- DATA->STOP after 8 bits.
- STOP->START if bytes remain or a message is pending.
- STOP->IDLE otherwise.
REQ-014 SHALL drive tx low in the cycle after a press_pulse sampled in IDLE (latency 1 cycle).
REQ-015 SHALL set a single pending flag on a press during an active message.
REQ-016 SHALL, on further presses while the pending flag is set, increment the count only; no additional message is queued.
REQ-017 SHALL start the pending message directly after the final stop bit, with no idle cycle, snapshotting the count at that point, and clear the pending flag.
REQ-018 SHALL treat a press in the last cycle of the final stop bit as pending, starting the next message the following cycle.
REQ-019 SHALL assert busy from the cycle tx first goes low until the final stop bit of the last message completes with no pending flag.

Reset
REQ-020 SHALL, while rst is high, force:
- tx=1, busy=0, press_count=0;
- pending flag cleared, state IDLE;
- bit and byte counters at 0.
REQ-021 SHALL abort any in-flight frame immediately on rst assertion, mid-bit included, with tx returning high asynchronously.
REQ-022 SHALL ignore press_pulse during reset and accept it from the first clk edge after rst deasserts.

Structure
REQ-023 SHALL place the FSM state enum, the CR/LF constants and the nibble-to-ASCII-hex function in shared package uart_pkg.
REQ-024 SHALL instantiate one sub-module uart_tx (byte-in/valid/ready serializer owning the baud and bit counters); press_reporter owns the count, the pending flag and message sequencing.

Verification
REQ-025 SHALL cover power-on reset: hold rst 5 cycles -> tx=1, busy=0, press_count=0 throughout.
REQ-026 SHALL cover a single message: with CLKS_PER_BIT=4, one press_pulse -> press_count=1; tx carries 0x30,0x31,0x0D,0x0A; busy high exactly 160 cycles.
REQ-027 SHALL cover the pending case: 3 pulses during the first message -> press_count=4; the first message sends "01"; the second sends "04" starting the cycle after the first's stop bit; no third message.
REQ-028 SHALL cover wrap-around: 255 spaced pulses, then one more -> last two messages "FF\r\n" and "00\r\n"; press_count=0.
REQ-029 SHALL cover reset mid-operation: rst during the DATA bits of byte 2 -> tx=1 the same cycle, busy=0, count=0; a following pulse sends "01".
REQ-030 SHALL cover the boundary press: a pulse on the last stop-bit cycle -> tx low the next cycle; busy never drops.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_pkg                                                          |
// | Brief   : Shared UART FSM states, line-ending bytes and hex-digit encoding. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [7:0] c_CR = 8'h0D;
  localparam logic [7:0] c_LF = 8'h0A;

  // Uppercase ASCII: '0'..'9' then 'A'..'F' ('A' - 10 = 0x37).
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      hex_ascii = 8'h30 + {4'h0, nibble};
    end else begin
      hex_ascii = 8'h37 + {4'h0, nibble};
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_tx                                                           |
// | Brief   : 8N1 byte serializer with valid/ready handshake, gapless chaining. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx
);

  localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  uart_state_t r_state, w_state_nxt;
  logic [15:0] r_baud,  w_baud_nxt;
  logic [2:0]  r_bit,   w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_tx,    w_tx_nxt;
  logic        w_baud_done;

  assign w_baud_done = (r_baud == c_BAUD_LAST);
  assign o_tx        = r_tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    o_ready     = 1'b0;

    case (r_state)
      IDLE: begin
        o_ready    = 1'b1;
        w_baud_nxt = 16'd0;
        w_tx_nxt   = 1'b1;
      end
      START: begin
        if (w_baud_done) begin
          w_state_nxt = DATA;
          w_baud_nxt  = 16'd0;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = 16'd0;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      STOP: begin
        if (w_baud_done) begin
          // Last stop-bit cycle: a waiting byte chains straight into START.
          o_ready     = 1'b1;
          w_state_nxt = IDLE;
          w_baud_nxt  = 16'd0;
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (o_ready && i_valid) begin
      w_state_nxt = START;
      w_baud_nxt  = 16'd0;
      w_bit_nxt   = 3'd0;
      w_shift_nxt = i_data;
      w_tx_nxt    = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/press_reporter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : press_reporter                                                    |
// | Brief   : Counts presses and reports each as "HH\r\n" over an 8N1 UART.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module press_reporter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press_pulse,
  output logic       tx,
  output logic       busy,
  output logic [7:0] press_count
);

  logic [7:0] r_count;
  logic [7:0] r_snap;
  logic [1:0] r_idx;
  logic       r_active;
  logic       r_pending;

  logic [7:0] w_count_nxt;
  logic       w_ready;
  logic       w_msg_done;
  logic       w_start;
  logic       w_next_byte;
  logic       w_valid;
  logic [7:0] w_data;

  assign w_count_nxt = r_count + {7'd0, press_pulse};
  assign w_msg_done  = r_active && w_ready && (r_idx == 2'd3);
  assign w_next_byte = r_active && w_ready && (r_idx != 2'd3);
  // A press on the final stop-bit cycle counts as pending and chains directly.
  assign w_start     = (!r_active && press_pulse) ||
                       (w_msg_done && (r_pending || press_pulse));
  assign w_valid     = w_start || w_next_byte;

  always_comb begin
    w_data = c_LF;
    if (w_start) begin
      w_data = hex_ascii(w_count_nxt[7:4]);
    end else begin
      case (r_idx)
        2'd0:    w_data = hex_ascii(r_snap[3:0]);
        2'd1:    w_data = c_CR;
        default: w_data = c_LF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= 8'd0;
      r_snap    <= 8'd0;
      r_idx     <= 2'd0;
      r_active  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_start) begin
        r_active <= 1'b1;
        r_idx    <= 2'd0;
        r_snap   <= w_count_nxt;
      end else if (w_next_byte) begin
        r_idx <= r_idx + 2'd1;
      end else if (w_msg_done) begin
        r_active <= 1'b0;
        r_idx    <= 2'd0;
      end

      if (w_start) begin
        r_pending <= 1'b0;
      end else if (r_active && press_pulse) begin
        r_pending <= 1'b1;
      end
    end
  end

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk     (clk),
    .rst     (rst),
    .i_data  (w_data),
    .i_valid (w_valid),
    .o_ready (w_ready),
    .o_tx    (tx)
  );

  assign busy        = r_active;
  assign press_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_press_reporter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_press_reporter                                                 |
// | Brief   : Directed self-checking bench for press_reporter (CLKS_PER_BIT=4). |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_press_reporter;

  logic       clk;
  logic       rst;
  logic       press_pulse;
  logic       tx;
  logic       busy;
  logic [7:0] press_count;

  int checks   = 0;
  int failures = 0;

  logic mon_clear = 1'b1;
  int   busy_hi   = 0;
  int   busy_lo   = 0;
  int   tx_lo     = 0;

  press_reporter #(
    .CLKS_PER_BIT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .press_pulse (press_pulse),
    .tx          (tx),
    .busy        (busy),
    .press_count (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_clear) begin
      busy_hi <= 0;
      busy_lo <= 0;
      tx_lo   <= 0;
    end else begin
      if (busy) busy_hi <= busy_hi + 1;
      else      busy_lo <= busy_lo + 1;
      if (!tx)  tx_lo   <= tx_lo + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    press_pulse = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_press();
    mon_clear   = 1'b1;
    press_pulse = 1'b1;
    tick();
    press_pulse = 1'b0;
    mon_clear   = 1'b0;
  endtask

  // Called on cycle 0 of a frame; returns on cycle 0 of the next frame slot.
  task automatic rx_frame(input bit press_en, input int press_at,
                          output logic [7:0] b, output bit ok);
    logic [9:0] bits;
    bit edge_ok;
    edge_ok = 1'b1;
    bits = '0;
    for (int i = 0; i < 40; i++) begin
      press_pulse = press_en && (i == press_at);
      if (i == 0  && tx !== 1'b0) edge_ok = 1'b0;
      if (i == 39 && tx !== 1'b1) edge_ok = 1'b0;
      if (i % 4 == 2) bits[i/4] = tx;
      tick();
    end
    press_pulse = 1'b0;
    b  = bits[8:1];
    ok = edge_ok && (bits[0] === 1'b0) && (bits[9] === 1'b1);
  endtask

  task automatic rx_msg(input logic [3:0] mask, input int press_at,
                        output logic [31:0] msg, output bit ok);
    logic [7:0] b;
    bit fok;
    ok  = 1'b1;
    msg = '0;
    for (int f = 0; f < 4; f++) begin
      rx_frame(mask[f], press_at, b, fok);
      msg = {msg[23:0], b};
      ok  = ok && fok;
    end
  endtask

  task automatic wait_idle(input int bound, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (busy === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    press_pulse = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({tx, busy, press_count} !== {1'b1, 1'b0, 8'h00}) begin
        failures++;
        $display("FAIL reset_hold[%0d]: tx/busy/count=%b/%b/%h required 1/0/00", i, tx, busy, press_count);
      end
    end
    press_pulse = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [31:0] msg;
    bit ok;
    start_press();
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1 || press_count !== 8'd1) begin
      failures++;
      $display("FAIL single_start: tx/busy/count=%b/%b/%h required 0/1/01", tx, busy, press_count);
    end
    rx_msg(4'b0000, 0, msg, ok);
    checks++;
    if (msg !== 32'h3031_0D0A) begin
      failures++;
      $display("FAIL single_msg: got %h required 30310d0a", msg);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_framing: got 0 required 1");
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (busy_hi !== 160 || busy_lo !== 8) begin
      failures++;
      $display("FAIL single_busy_len: busy_hi/lo=%0d/%0d required 160/8", busy_hi, busy_lo);
    end
    checks++;
    if (tx !== 1'b1 || press_count !== 8'd1) begin
      failures++;
      $display("FAIL single_idle: tx/count=%b/%h required 1/01", tx, press_count);
    end
  endtask

  task automatic test_pending();
    logic [31:0] msg;
    bit ok;
    do_reset();
    start_press();
    rx_msg(4'b0111, 10, msg, ok);
    checks++;
    if (msg !== 32'h3031_0D0A || !ok) begin
      failures++;
      $display("FAIL pending_first: got %h ok=%0d required 30310d0a ok=1", msg, ok);
    end
    checks++;
    if (press_count !== 8'd4) begin
      failures++;
      $display("FAIL pending_count: got %h required 04", press_count);
    end
    rx_msg(4'b0000, 0, msg, ok);
    checks++;
    if (msg !== 32'h3034_0D0A || !ok) begin
      failures++;
      $display("FAIL pending_second: got %h ok=%0d required 30340d0a ok=1", msg, ok);
    end
    checks++;
    if (busy_hi !== 320 || busy_lo !== 0) begin
      failures++;
      $display("FAIL pending_busy: busy_hi/lo=%0d/%0d required 320/0", busy_hi, busy_lo);
    end
    mon_clear = 1'b1;
    tick();
    mon_clear = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    checks++;
    if (busy_hi !== 0 || tx_lo !== 0) begin
      failures++;
      $display("FAIL pending_no_third: busy_hi/tx_lo=%0d/%0d required 0/0", busy_hi, tx_lo);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] msg;
    bit ok;
    bit to;
    do_reset();
    for (int i = 0; i < 254; i++) begin
      press_pulse = 1'b1;
      tick();
      press_pulse = 1'b0;
      tick();
    end
    wait_idle(2000, to);
    checks++;
    if (to || press_count !== 8'hFE) begin
      failures++;
      $display("FAIL wrap_drain: timeout=%0d count=%h required 0/fe", to, press_count);
    end
    start_press();
    rx_msg(4'b0000, 0, msg, ok);
    checks++;
    if (msg !== 32'h4646_0D0A || !ok) begin
      failures++;
      $display("FAIL wrap_ff: got %h ok=%0d required 46460d0a ok=1", msg, ok);
    end
    start_press();
    rx_msg(4'b0000, 0, msg, ok);
    checks++;
    if (msg !== 32'h3030_0D0A || !ok) begin
      failures++;
      $display("FAIL wrap_00: got %h ok=%0d required 30300d0a ok=1", msg, ok);
    end
    checks++;
    if (press_count !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_count: count/busy=%h/%b required 00/0", press_count, busy);
    end
  endtask

  task automatic test_reset_midop();
    logic [7:0]  b;
    logic [31:0] msg;
    bit ok;
    do_reset();
    start_press();
    rx_frame(1'b0, 0, b, ok);
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({tx, busy, press_count} !== {1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL midop_async: tx/busy/count=%b/%b/%h required 1/0/00", tx, busy, press_count);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({tx, busy, press_count} !== {1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL midop_after: tx/busy/count=%b/%b/%h required 1/0/00", tx, busy, press_count);
    end
    start_press();
    rx_msg(4'b0000, 0, msg, ok);
    checks++;
    if (msg !== 32'h3031_0D0A || !ok) begin
      failures++;
      $display("FAIL midop_msg: got %h ok=%0d required 30310d0a ok=1", msg, ok);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] msg;
    bit ok;
    do_reset();
    start_press();
    rx_msg(4'b1000, 39, msg, ok);
    checks++;
    if (msg !== 32'h3031_0D0A || !ok) begin
      failures++;
      $display("FAIL b2b_first: got %h ok=%0d required 30310d0a ok=1", msg, ok);
    end
    checks++;
    if (tx !== 1'b0 || press_count !== 8'd2) begin
      failures++;
      $display("FAIL b2b_next_start: tx/count=%b/%h required 0/02", tx, press_count);
    end
    rx_msg(4'b0000, 0, msg, ok);
    checks++;
    if (msg !== 32'h3032_0D0A || !ok) begin
      failures++;
      $display("FAIL b2b_second: got %h ok=%0d required 30320d0a ok=1", msg, ok);
    end
    checks++;
    if (busy_hi !== 320 || busy_lo !== 0) begin
      failures++;
      $display("FAIL b2b_busy: busy_hi/lo=%0d/%0d required 320/0", busy_hi, busy_lo);
    end
  endtask

  initial begin
    rst = 1'b1;
    press_pulse = 1'b0;
    test_reset();
    test_single();
    test_pending();
    test_wrap();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
